// File: rtl/sm_display_pkg.sv
// Shared types, constants and helpers for the multiplexed hex display.
// Segment patterns here are active-high gfedcba; polarity is applied at the pins.
package sm_display_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

  // Counter width helper: never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1100111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      4'hF: s = 7'b1110001;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sm_display_scan_timer.sv
// Slot/digit scan counters for the hex display.
// Produces the current digit index, dead-time flag and frame tick.
module sm_display_scan_timer
  import sm_display_pkg::*;
#(
  parameter int N_DIGITS        = 8,
  parameter int TICKS_PER_DIGIT = 1024,
  parameter int DEAD_TICKS      = 16,
  localparam int IW = cnt_width(N_DIGITS),
  localparam int CW = cnt_width(TICKS_PER_DIGIT)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [IW-1:0] o_idx,
  output logic          o_in_dead,
  output logic          o_frame_tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;

  // Slot counter wraps every TICKS_PER_DIGIT cycles and steps the digit index.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Dead time covers the first DEAD_TICKS cycles of every slot.
  if (DEAD_TICKS == 0) begin : g_no_dead
    assign o_in_dead = 1'b0;
  end else begin : g_dead
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD_TICKS);
    assign o_in_dead = (r_cnt < DEAD_C);
  end

  assign o_idx        = r_idx;
  assign o_frame_tick = (r_idx == '0) && (r_cnt == '0);

endmodule

// File: rtl/sm_hex_display_scan.sv
// Multiplexed hex display driver with per-frame snapshot,
// leading-zero blanking, dead time and configurable pin polarity.
module sm_hex_display_scan
  import sm_display_pkg::*;
#(
  parameter int N_DIGITS        = 8,
  parameter int TICKS_PER_DIGIT = 1024,
  parameter int DEAD_TICKS      = 16,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int AN_ACTIVE_LOW   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] number,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  blank_zeros,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_start
);

  localparam int IW = cnt_width(N_DIGITS);
  localparam int NW = 4 * N_DIGITS;

  localparam logic [N_DIGITS-1:0] AN_MASK =
    (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0] SEG_MASK =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DOT_MASK = (SEG_ACTIVE_LOW != 0);

  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_n
    $error("N_DIGITS out of range 1..16");
  end
  if (TICKS_PER_DIGIT < 2) begin : g_bad_t
    $error("TICKS_PER_DIGIT must be at least 2");
  end
  if (DEAD_TICKS < 0 || DEAD_TICKS >= TICKS_PER_DIGIT) begin : g_bad_d
    $error("DEAD_TICKS must be in 0..TICKS_PER_DIGIT-1");
  end

  logic [IW-1:0] w_idx;
  logic          w_in_dead;
  logic          w_frame_tick;

  sm_display_scan_timer #(
    .N_DIGITS        (N_DIGITS),
    .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
    .DEAD_TICKS      (DEAD_TICKS)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .o_idx        (w_idx),
    .o_in_dead    (w_in_dead),
    .o_frame_tick (w_frame_tick)
  );

  logic [NW-1:0]       r_num_s;
  logic [N_DIGITS-1:0] r_dots_s;
  logic [N_DIGITS-1:0] r_en_s;
  logic                r_blank_s;

  // Shadow copy of the display inputs, refreshed once per frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_num_s   <= '0;
      r_dots_s  <= '0;
      r_en_s    <= '0;
      r_blank_s <= 1'b0;
    end else if (w_frame_tick) begin
      r_num_s   <= number;
      r_dots_s  <= dots;
      r_en_s    <= digit_en;
      r_blank_s <= blank_zeros;
    end
  end

  // The snapshot cycle itself already renders with the fresh values,
  // so slot 0 is correct even without dead time.
  logic [NW-1:0]       w_num;
  logic [N_DIGITS-1:0] w_dots;
  logic [N_DIGITS-1:0] w_en;
  logic                w_blank;

  assign w_num   = w_frame_tick ? number      : r_num_s;
  assign w_dots  = w_frame_tick ? dots        : r_dots_s;
  assign w_en    = w_frame_tick ? digit_en    : r_en_s;
  assign w_blank = w_frame_tick ? blank_zeros : r_blank_s;

  logic [N_DIGITS-1:0] w_lz;
  logic                w_zero_run;

  // Leading-zero map: a digit is leading when it and all higher nibbles are 0.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (w_num[4*i +: 4] == 4'h0);
      w_lz[i]    = w_zero_run && (i != 0);
    end
  end

  logic [3:0]          w_nib;
  logic                w_en_d;
  logic                w_dot_d;
  logic                w_lz_d;
  logic [N_DIGITS-1:0] w_sel;

  // Pick the attributes of the digit currently being scanned.
  always_comb begin
    w_nib   = 4'h0;
    w_en_d  = 1'b0;
    w_dot_d = 1'b0;
    w_lz_d  = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_idx == IW'(i)) begin
        w_nib    = w_num[4*i +: 4];
        w_en_d   = w_en[i];
        w_dot_d  = w_dots[i];
        w_lz_d   = w_lz[i];
        w_sel[i] = 1'b1;
      end
    end
  end

  phase_e              w_phase;
  logic                w_vis;
  logic [N_DIGITS-1:0] w_an_n;
  logic [6:0]          w_seg_n;
  logic                w_dot_n;

  assign w_phase = w_in_dead ? PH_BLANK : PH_SHOW;
  assign w_vis   = w_en_d && !(w_blank && w_lz_d);

  // Active-high next outputs; everything stays dark during dead time.
  always_comb begin
    w_an_n  = '0;
    w_seg_n = SEG_BLANK;
    w_dot_n = 1'b0;
    if (w_phase == PH_SHOW) begin
      if (w_en_d && (w_vis || w_dot_d)) begin
        w_an_n = w_sel;
      end
      if (w_vis) begin
        w_seg_n = hex_to_seg(w_nib);
      end
      w_dot_n = w_en_d && w_dot_d;
    end
  end

  // Registered pin drivers with polarity applied last.
  always_ff @(posedge clock) begin
    if (reset) begin
      anodes         <= AN_MASK;
      seven_segments <= SEG_MASK;
      dot            <= DOT_MASK;
      frame_start    <= 1'b0;
    end else begin
      anodes         <= w_an_n ^ AN_MASK;
      seven_segments <= w_seg_n ^ SEG_MASK;
      dot            <= w_dot_n ^ DOT_MASK;
      frame_start    <= w_frame_tick;
    end
  end

endmodule

// File: doc/sm_hex_display_scan.md
# sm_hex_display_scan

Parametrised multiplexed hex display driver: successor to the fixed 8-digit scanner, with configurable digit count, refresh rate, output polarity, per-digit enable and dot, optional leading-zero blanking, and an anti-ghosting dead time between digits. The displayed value is snapshotted once per frame, so a digit never shows a half-updated value. It sits between the SoC's memory-mapped display register and the board's common-anode/cathode LED pins.

## Interface
- N_DIGITS, 8: number of digits scanned; legal range 1..16.
- TICKS_PER_DIGIT, 1024: clock cycles per digit slot; must be ≥ 2.
- DEAD_TICKS, 16: cycles at the start of each slot with all anodes off; 0 ≤ DEAD_TICKS < TICKS_PER_DIGIT, otherwise elaboration error.
- SEG_ACTIVE_LOW, 1: 1 means segments and dot are driven low when lit.
- AN_ACTIVE_LOW, 1: 1 means anodes are driven low when selected.

- clock  in  1  system clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- number  in  4*N_DIGITS  hex value. Nibble i is digit i; digit 0 is rightmost.
- dots  in  N_DIGITS  dot request per digit.
- digit_en  in  N_DIGITS  per-digit enable; a disabled digit is dark.
- blank_zeros  in  1  suppresses leading zeros when high.
- seven_segments  out  7  segment bits; bit0 = a … bit6 = g.
- dot  out  1  decimal point.
- anodes  out  N_DIGITS  digit select, one-hot when lit.
- frame_start  out  1  one-cycle pulse marking the first output cycle of a new frame.

## Operation
- Counters:
  - cnt runs 0..TICKS_PER_DIGIT-1.
  - idx advances by 1 when cnt wraps, and wraps N_DIGITS-1 → 0.
- Snapshot: in any cycle with idx = 0 and cnt = 0, the shadow registers load number, dots, digit_en and blank_zeros. Inputs that change mid-frame have no effect until the next snapshot.
- Phase:
  - cnt < DEAD_TICKS is the BLANK phase: every output is inactive.
  - Otherwise the phase is SHOW.
- Leading zero: digit idx is a leading zero when idx ≠ 0, and nibble idx and every higher nibble of the shadow number are 0. Digit 0 is never blanked, so a value of 0 displays "0".
- visible = en_s[idx] && !(blank_s && leading_zero(idx)).
- In SHOW:
  - anodes select idx if en_s[idx] && (visible || dots_s[idx]).
  - seven_segments = hex pattern of nibble idx if visible, else all off.
  - dot is lit if en_s[idx] && dots_s[idx]. A requested dot is therefore shown even on a zero-blanked digit.
- Hex patterns, active-high gfedcba: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Polarity is applied last: an output is inverted when its ACTIVE_LOW parameter is 1.
- Reset values:
  - cnt = 0, idx = 0, shadow registers = 0.
  - anodes, seven_segments and dot inactive: all ones when the matching ACTIVE_LOW parameter is 1.
  - frame_start = 0.

## Timing
- All outputs are registered. The output in cycle t reflects (idx, cnt, shadow) from cycle t-1.
- Frame length = N_DIGITS*TICKS_PER_DIGIT cycles. Each digit is lit for TICKS_PER_DIGIT-DEAD_TICKS cycles per frame.
- frame_start is high in the output cycle produced by the idx = 0, cnt = 0 state, and only then.
- First cycle after reset deasserts: snapshot is taken. One cycle later frame_start = 1 and outputs show slot 0. With DEAD_TICKS = 0 the first digit is lit immediately.
- DEAD_TICKS = 0: no blank gap; the anode changes directly between adjacent digits.
- N_DIGITS = 1: idx stays at 0; a snapshot is taken every TICKS_PER_DIGIT cycles.
- Reset asserted mid-slot: outputs take reset values on the next edge. The scan restarts from digit 0, and no partial frame is completed.
- Counter widths: $clog2(TICKS_PER_DIGIT) and $clog2(N_DIGITS), minimum 1 bit each. No other arithmetic may overflow.

## Structure
- Package sm_display_pkg holds:
  - the hex-to-segment function (active-high gfedcba);
  - the constant SEG_BLANK;
  - the digit-count limit MAX_DIGITS = 16.
- Sub-module sm_display_scan_timer holds the cnt/idx counters. Outputs: idx, in_dead, frame_tick.
- The top level holds shadow registers, blanking logic, polarity and output registers.

## Test plan
Configuration for all cases: N_DIGITS=4, TICKS_PER_DIGIT=4, DEAD_TICKS=1, both polarities active-low.
1. Hold reset 3 cycles, then release. During reset: anodes=1111, seven_segments=1111111, dot=1, frame_start=0. One cycle after release: frame_start=1.
2. number=16'h1234, digit_en=1111, blank_zeros=0.
   - Slot 0: 1 cycle anodes=1111, then 3 cycles anodes=1110 with seven_segments=0011001 ("4").
   - Digit 3 shows "1" (1111001) with anodes=0111.
   - frame_start pulses every 16 cycles.
3. blank_zeros=1, number=16'h0050. Digits 3 and 2 never select an anode. Digit 1 shows 0010010; digit 0 shows 1000000. With number=0, only digit 0 lights, showing "0".
4. blank_zeros=1, number=16'h0007, dots=1000. Digit 3 slot: anodes=0111, seven_segments=1111111, dot=0.
5. number changes from 16'h1111 to 16'h2222 during the digit 1 slot. The rest of the frame shows "1". After the next frame_start, all digits show "2" (0100100).
6. Assert reset during the digit 2 SHOW phase for 1 cycle. Next cycle shows reset values. The scan resumes at digit 0, with frame_start exactly one cycle after deassertion.
